// File: rtl/stepper_drv.sv
// stepper_drv: clock-enable stepper driver with programmable period, step-count moves and signed position
// Ports: clk; rst (synchronous, active-low); start/stop move control; dir, half_step, period, steps
//        latched when a move starts; hold keeps the coils energised while idle; OUT_A/OUT_B/OUT_nA/OUT_nB
//        registered coil drives; busy = move in progress; done = end-of-move pulse; position = signed steps.
// Option: define STEPPER_RAMP_EN to start each move at max(RAMP_START, period) and speed up by one tick per step.
module stepper_drv #(
    parameter int PRESCALE   = 125000,
    parameter int PERIOD_W   = 8,
    parameter int COUNT_W    = 16,
    parameter int POS_W      = 16,
    parameter int RAMP_START = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                dir,
    input  logic                half_step,
    input  logic                hold,
    input  logic [PERIOD_W-1:0] period,
    input  logic [COUNT_W-1:0]  steps,
    output logic                OUT_A,
    output logic                OUT_B,
    output logic                OUT_nA,
    output logic                OUT_nB,
    output logic                busy,
    output logic                done,
    output logic [POS_W-1:0]    position
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    // phase table packed with index 7 in the top nibble, each entry {A,B,nA,nB}
    localparam logic [31:0] PHASES = 32'h9132_64C8;
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [PW-1:0] pre;
    logic tick, go, step, last, done_n, dir_l, half_l;
    logic [PERIOD_W-1:0] per0, per_l, tdown, tdown_n;
    logic [COUNT_W-1:0] steps_l, cnt, cnt_n, cnt_inc;
    logic [2:0] idx, idx_n, inc;
    logic [POS_W-1:0] pos_n;
    logic [3:0] coil_n;
`ifdef STEPPER_RAMP_EN
    logic [PERIOD_W-1:0] eff, eff_n;
`endif
    assign tick = pre == PW'(PRESCALE - 1);
    assign per0 = period == '0 ? PERIOD_W'(1) : period;
    assign go = state == IDLE && start && !stop;
    assign cnt_inc = cnt + COUNT_W'(1);
    // odd indices are the two-phase positions; an even index is first nudged onto one
    assign inc = (half_l || !idx[0]) ? 3'd1 : 3'd2;
    always_comb begin
        state_n = state;
        tdown_n = tdown;
        cnt_n = cnt;
        idx_n = idx;
        pos_n = position;
        done_n = 1'b0;
        step = 1'b0;
        last = 1'b0;
`ifdef STEPPER_RAMP_EN
        eff_n = eff;
`endif
        if (go) begin
            state_n = RUN;
            cnt_n = '0;
`ifdef STEPPER_RAMP_EN
            eff_n = RAMP_START > int'(per0) ? PERIOD_W'(RAMP_START) : per0;
            tdown_n = eff_n;
`else
            tdown_n = per0;
`endif
        end else if (state == RUN) begin
            step = tick && tdown == PERIOD_W'(1);
            last = step && steps_l != '0 && cnt_inc == steps_l;
            if (tick)
                tdown_n = tdown - PERIOD_W'(1);
            // a stop only pre-empts steps that would not finish the move anyway
            if (stop && !last) begin
                state_n = IDLE;
                done_n = 1'b1;
            end else if (step) begin
`ifdef STEPPER_RAMP_EN
                eff_n = eff > per_l ? eff - PERIOD_W'(1) : eff;
                tdown_n = eff_n;
`else
                tdown_n = per_l;
`endif
                cnt_n = cnt_inc;
                idx_n = dir_l ? idx + inc : idx - inc;
                pos_n = dir_l ? position + POS_W'(1) : position - POS_W'(1);
                state_n = last ? IDLE : RUN;
                done_n = last;
            end
        end
        coil_n = (state_n == RUN || hold) ? PHASES[{idx_n, 2'b00} +: 4] : 4'b0000;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            pre <= '0;
            tdown <= '0;
            cnt <= '0;
            idx <= '0;
            position <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            {OUT_A, OUT_B, OUT_nA, OUT_nB} <= 4'b0000;
            dir_l <= 1'b0;
            half_l <= 1'b0;
            per_l <= PERIOD_W'(1);
            steps_l <= '0;
`ifdef STEPPER_RAMP_EN
            eff <= PERIOD_W'(1);
`endif
        end else begin
            state <= state_n;
            pre <= (go || tick) ? '0 : pre + PW'(1);
            tdown <= tdown_n;
            cnt <= cnt_n;
            idx <= idx_n;
            position <= pos_n;
            busy <= state_n == RUN;
            done <= done_n;
            {OUT_A, OUT_B, OUT_nA, OUT_nB} <= coil_n;
            if (go) begin
                dir_l <= dir;
                half_l <= half_step;
                per_l <= per0;
                steps_l <= steps;
            end
`ifdef STEPPER_RAMP_EN
            eff <= eff_n;
`endif
        end
    end
endmodule

// File: tb/tb_stepper_drv.sv
// tb_stepper_drv: scoreboard bench for stepper_drv; stimulus queues expected step/done events, a monitor checks them
module tb_stepper_drv;
    localparam int P = 3;
    localparam int RS = 5;
    logic clk = 0, rst = 0, start = 0, stop = 0, dir = 0, half_step = 0, hold = 0;
    logic [7:0] period = 0;
    logic [15:0] steps = 0;
    logic oa, ob, ona, onb, busy, done;
    logic [3:0] position;
    stepper_drv #(.PRESCALE(P), .PERIOD_W(8), .COUNT_W(16), .POS_W(4), .RAMP_START(RS)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .half_step(half_step),
        .hold(hold), .period(period), .steps(steps), .OUT_A(oa), .OUT_B(ob), .OUT_nA(ona),
        .OUT_nB(onb), .busy(busy), .done(done), .position(position)
    );
    always #5 clk = ~clk;
    typedef struct {
        int c;
        logic [3:0] coil;
        logic [3:0] pos;
        logic dn;
    } ev_t;
    ev_t q[$];
    int checks = 0, failures = 0, cyc = 0;
    bit mon_en = 0;
    logic [3:0] prev_pos = 0;
    logic [3:0] tbl [8] = '{4'h8, 4'hC, 4'h4, 4'h6, 4'h2, 4'h3, 4'h1, 4'h9};
    int m_idx = 0;
    logic [3:0] m_pos = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask
    always @(negedge clk) begin
        ev_t e;
        if (mon_en && (position !== prev_pos || done)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got pos=%0h done=%0b at cycle %0d expected no event", position, done, cyc);
            end else begin
                e = q.pop_front();
                chk("ev_cycle", cyc, e.c);
                chk("ev_coil", {oa, ob, ona, onb}, e.coil);
                chk("ev_pos", position, e.pos);
                chk("ev_done", done, e.dn);
                chk("ev_busy", busy, !e.dn);
            end
        end
        prev_pos = position;
    end
    task automatic do_start(input logic d, input logic hs, input logic hl, input logic [7:0] per,
                            input logic [15:0] st, input int n, output int s);
        ev_t e;
        int t, eff, per0, inc;
        @(negedge clk);
        dir = d; half_step = hs; hold = hl; period = per; steps = st; start = 1;
        @(posedge clk);
        #1;
        s = cyc;
        start = 0;
        dir = ~d; half_step = ~hs; period = per + 8'd3; steps = st + 16'd7;
        chk("busy_after_start", busy, 1);
        per0 = per == 0 ? 1 : int'(per);
        eff = per0;
`ifdef STEPPER_RAMP_EN
        eff = RS > per0 ? RS : per0;
`endif
        t = s;
        for (int k = 1; k <= n; k++) begin
            t += eff * P;
            inc = (hs || m_idx % 2 == 0) ? 1 : 2;
            m_idx = d ? (m_idx + inc) % 8 : (m_idx + 8 - inc) % 8;
            m_pos = d ? m_pos + 4'd1 : m_pos - 4'd1;
            e.c = t;
            e.dn = st != 0 && k == int'(st);
            e.coil = (e.dn && !hl) ? 4'h0 : tbl[m_idx];
            e.pos = m_pos;
            q.push_back(e);
            if (eff > per0) eff--;
        end
    endtask
    task automatic wait_empty(input int lim);
        for (int i = 0; i < lim && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            chk("event_timeout", q.size(), 0);
            q.delete();
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        #1;
        mon_en = 0;
        rst = 0;
        @(negedge clk);
        #1;
        chk("rst_coils", {oa, ob, ona, onb}, 4'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pos", position, 4'h0);
        rst = 1;
        m_idx = 0;
        m_pos = 0;
        q.delete();
        @(negedge clk);
        #1;
        mon_en = 1;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        int s;
        ev_t e;
        do_reset();
        hold = 1;
        @(negedge clk);
        #1;
        chk("idle_hold_idx0", {oa, ob, ona, onb}, 4'h8);
        // half-step forward: 1100 0100 0110 0010, position 4
        do_start(1, 1, 1, 3, 4, 4, s);
        wait_empty(300);
        @(negedge clk);
        #1;
        chk("t1_busy_end", busy, 0);
        chk("t1_hold_coils", {oa, ob, ona, onb}, 4'h2);
        chk("t1_pos", position, 4'd4);
        // full-step reverse from index 0: 1001 0011 0110, position -3
        do_reset();
        do_start(0, 0, 1, 2, 3, 3, s);
        wait_empty(300);
        chk("t2_pos", position, 4'hD);
        // continuous run stopped after 10 steps, hold=0 drops coils
        do_start(1, 0, 0, 1, 0, 10, s);
        wait_empty(300);
        stop = 1;
        e.c = cyc + 1; e.coil = 4'h0; e.pos = m_pos; e.dn = 1;
        q.push_back(e);
        @(negedge clk);
        #1;
        stop = 0;
        wait_empty(10);
        chk("t3_coils_off", {oa, ob, ona, onb}, 4'h0);
        chk("t3_pos", position, 4'h7);
        // period 0 acts as 1; second start mid-move ignored
        do_start(0, 1, 1, 0, 2, 2, s);
        @(negedge clk);
        #1;
        dir = 1; period = 5; steps = 9; start = 1;
        @(negedge clk);
        #1;
        start = 0;
        wait_empty(100);
        // stop and start together in IDLE: nothing starts, no done
        @(negedge clk);
        start = 1; stop = 1;
        @(negedge clk);
        #1;
        start = 0; stop = 0;
        repeat (4) @(negedge clk);
        #1;
        chk("stop_start_idle_busy", busy, 0);
        // stop coinciding with the final step: step taken, one done
        do_start(1, 1, 1, 1, 2, 2, s);
        while (cyc < s + 5) @(negedge clk);
        #1;
        stop = 1;
        @(negedge clk);
        #1;
        stop = 0;
        wait_empty(50);
        chk("coincide_pos", position, 4'h7);
        // 9 reverse half steps from 0 wrap to 4'b0111
        do_reset();
        do_start(0, 1, 0, 1, 9, 9, s);
        wait_empty(300);
        chk("t5_wrap_pos", position, 4'b0111);
        // reset mid-move aborts without done
        do_reset();
        do_start(1, 1, 0, 2, 0, 5, s);
        wait_empty(400);
        do_reset();
        repeat (30) @(negedge clk);
        #1;
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_pos_after_rst", position, 4'h0);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
